imem_port_ctrl: RTL
===================

Name: imem_port_ctrl

Overview:
- Sequences port 0 (read/write) of the 32x512 instruction SRAM for the SLRV core.
- Shares port 0 between a Wishbone slave (caravel management SoC) and a logic-analyzer loader path.
- Holds the core in reset while the program is loaded.
- Core fetch on SRAM port 1 is untouched; this block owns csb0/web0/wmask0/addr0/din0 and samples dout0.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base of the IMEM window (2 KB, word-addressed).
- CTRL_OFFSET, 32'h0000_0800, byte offset of the control register.
- ADDR_W, 9, SRAM word address width.

Ports:
- wb_clk_i  in  1  sole clock, also drives SRAM clk0.
- reset_n  in  1  synchronous, active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- la_wr_req  in  1  level request from the LA loader.
- la_addr  in  ADDR_W  LA word address.
- la_data  in  32  LA write data.
- la_wr_done  out  1  one-cycle pulse when the LA write completes.
- csb0  out  1  SRAM port-0 chip select, active-low.
- web0  out  1  SRAM port-0 write enable, active-low.
- wmask0  out  4  SRAM byte mask.
- addr0  out  ADDR_W  SRAM word address.
- din0  out  32  SRAM write data.
- dout0  in  32  SRAM read data.
- core_reset  out  1  active-high reset to the SLRV core.

Behaviour:
- Reset (reset_n=0 at a clock edge) values:
  - FSM to IDLE.
  - csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
  - wbs_ack_o=0, wbs_dat_o=0, la_wr_done=0.
  - core_hold=1, so core_reset=1.
  - Reset mid-access aborts the access; no ack or done is issued.
- Address decode:
  - IMEM hit when wbs_adr_i[31:11]==BASE_ADDR[31:11]; word = wbs_adr_i[10:2].
  - CTRL hit when address == BASE_ADDR+CTRL_OFFSET.
  - Any other address is ignored (no ack).
- FSM states and transitions:
  - IDLE: arbitrate between LA and Wishbone (rules below).
  - LA_WR: csb0=0, web0=0, wmask0=4'hF, addr0=la_addr, din0=la_data for one cycle. Next state DONE, which pulses la_wr_done.
  - WB_WR: csb0=0, web0=0, wmask0=wbs_sel_i, word address, din0=wbs_dat_i for one cycle. Next state ACK.
  - WB_RD: csb0=0, web0=1 for one cycle. Next state RD_WAIT, which latches dout0 into wbs_dat_o. Next state ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
  - CTRL access (IDLE to ACK directly):
    - Write: bit0 sets core_hold from wbs_dat_i[0] when wbs_sel_i[0]=1.
    - Read: returns {31'b0, core_hold}.
- Latency from request seen in IDLE:
  - LA write: done pulse at +2.
  - WB write: ack at +2.
  - WB read: ack at +3.
  - CTRL: ack at +1.
- Arbitration in IDLE:
  - LA has priority over Wishbone.
  - A Wishbone request waiting behind LA is served on the next IDLE visit.
  - A held la_wr_req is re-served each IDLE visit, so the loader must drop the request after la_wr_done.
  - Strict alternation: after serving LA, a pending Wishbone request wins the next IDLE, so neither side starves.
- Outside active states: csb0=1 and web0=1.
- core_reset is registered from core_hold.
- wbs_cyc_i dropping before ack:
  - A transaction already issued to the SRAM completes, but the ack is suppressed.
  - A request not yet accepted is discarded.

Optional Feature:
- Macro: IMEM_READBACK_EN.
- Defined: WB_RD/RD_WAIT behave as described above.
- Undefined: Wishbone reads of the IMEM window ack at +1 with data 0 and no SRAM access. This saves the dout0 capture register; CTRL reads are unaffected.

Decomposition:
- Shared package imem_pkg:
  - FSM state enum: IDLE, LA_WR, WB_WR, WB_RD, RD_WAIT, ACK, DONE.
  - IMEM_WORDS=512.
  - Default BASE_ADDR and CTRL_OFFSET.
- One sub-module, imem_wb_decode: combinational address decode producing imem_hit, ctrl_hit and word address.

Test Plan:
- Reset, then CTRL read at 0x3000_0800 -> ack at +1, data 32'h1, core_reset=1.
- WB write 0x3000_0010, data 32'hDEADBEEF, sel 4'hF -> single cycle with csb0=0, web0=0, addr0=4, din0=DEADBEEF; ack at +2.
- (IMEM_READBACK_EN) WB read 0x3000_0010 with dout0 model returning DEADBEEF -> csb0=0 with web0=1 for one cycle, ack at +3, wbs_dat_o=DEADBEEF.
- la_wr_req and WB write asserted in the same cycle (la_addr=9'h1FF) -> LA_WR first with addr0=1FF, la_wr_done at +2; WB write then served with ack at +4.
- WB partial write with sel 4'b0101 -> wmask0=4'b0101. CTRL write of 0 -> core_reset=0 within 2 cycles.
- reset_n=0 during WB_RD -> no ack, csb0=1 next cycle, core_reset=1.

Source files
------------

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the SLRV instruction-memory port-0 controller:
//   - imem_state_e : port-0 sequencer states
//   - IMEM_WORDS   : depth of the 32-bit instruction SRAM
//   - BASE_ADDR_DEFAULT / CTRL_OFFSET_DEFAULT : default Wishbone placement
//   - ctrl_word()  : read-back format of the control register
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int          IMEM_WORDS          = 512;
  localparam logic [31:0] BASE_ADDR_DEFAULT   = 32'h3000_0000;
  localparam logic [31:0] CTRL_OFFSET_DEFAULT = 32'h0000_0800;

  typedef enum logic [2:0] {
    IDLE,
    LA_WR,
    WB_WR,
    WB_RD,
    RD_WAIT,
    ACK,
    DONE
  } imem_state_e;

  // Control register image: only bit 0 (core hold) is implemented.
  function automatic logic [31:0] ctrl_word(input logic hold);
    return {31'b0, hold};
  endfunction

endpackage

// File: rtl/imem_wb_decode.sv
// -----------------------------------------------------------------------------
// imem_wb_decode
// Combinational Wishbone address decode for the IMEM window.
// Ports:
//   wbs_adr_i  in   32      Wishbone byte address
//   imem_hit   out  1       address falls in the 2 KB IMEM window
//   ctrl_hit   out  1       address is exactly the control register
//   word_addr  out  ADDR_W  SRAM word address (byte address / 4)
// -----------------------------------------------------------------------------
module imem_wb_decode
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter logic [31:0] CTRL_OFFSET = CTRL_OFFSET_DEFAULT,
  parameter int          ADDR_W      = 9
) (
  input  logic [31:0]       wbs_adr_i,
  output logic              imem_hit,
  output logic              ctrl_hit,
  output logic [ADDR_W-1:0] word_addr
);

  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + CTRL_OFFSET;

  // The control register wins if a custom placement ever overlaps the window.
  assign ctrl_hit  = (wbs_adr_i == CTRL_ADDR);
  assign imem_hit  = !ctrl_hit && (wbs_adr_i[31:11] == BASE_ADDR[31:11]);
  assign word_addr = wbs_adr_i[ADDR_W+1:2];

endmodule

// File: rtl/imem_port_ctrl.sv
// -----------------------------------------------------------------------------
// imem_port_ctrl
// Sequences port 0 of the 32x512 instruction SRAM, shared between the caravel
// Wishbone slave and the logic-analyzer program loader, and holds the SLRV core
// in reset while a program is loaded. Core fetch on port 1 is not touched.
//
// Optional feature macro: IMEM_READBACK_EN
//   defined   : Wishbone reads of the IMEM window go through the SRAM
//               (WB_RD -> RD_WAIT -> ACK, ack three cycles after the request).
//   undefined : such reads ack one cycle after the request with data 0 and no
//               SRAM access; dout0 is not captured.
//
// Ports:
//   wb_clk_i     in   1       sole clock (also SRAM clk0)
//   reset_n      in   1       synchronous active-low reset
//   wbs_*_i      in           Wishbone slave inputs (stb, cyc, we, sel, adr, dat)
//   wbs_ack_o    out  1       single-cycle acknowledge
//   wbs_dat_o    out  32      read data
//   la_wr_req    in   1       level write request from the LA loader
//   la_addr      in   ADDR_W  LA word address
//   la_data      in   32      LA write data
//   la_wr_done   out  1       one-cycle pulse when the LA write has completed
//   csb0/web0    out  1       SRAM port-0 chip select / write enable (active low)
//   wmask0       out  4       SRAM byte mask
//   addr0        out  ADDR_W  SRAM word address
//   din0         out  32      SRAM write data
//   dout0        in   32      SRAM read data
//   core_reset   out  1       active-high reset to the SLRV core
// -----------------------------------------------------------------------------
module imem_port_ctrl
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter logic [31:0] CTRL_OFFSET = CTRL_OFFSET_DEFAULT,
  parameter int          ADDR_W      = 9
) (
  input  logic              wb_clk_i,
  input  logic              reset_n,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              la_wr_req,
  input  logic [ADDR_W-1:0] la_addr,
  input  logic [31:0]       la_data,
  output logic              la_wr_done,
  output logic              csb0,
  output logic              web0,
  output logic [3:0]        wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [31:0]       din0,
  input  logic [31:0]       dout0,
  output logic              core_reset
);

  imem_state_e       state_reg, state_next;
  logic              csb0_reg, csb0_next;
  logic              web0_reg, web0_next;
  logic [3:0]        wmask0_reg, wmask0_next;
  logic [ADDR_W-1:0] addr0_reg, addr0_next;
  logic [31:0]       din0_reg, din0_next;
  logic              ack_reg, ack_next;
  logic [31:0]       dat_reg, dat_next;
  logic              done_reg, done_next;
  logic              hold_reg, hold_next;
  logic              core_reset_reg;
  logic              la_last_reg, la_last_next;
  logic              abort_reg, abort_next;

  logic              imem_hit;
  logic              ctrl_hit;
  logic [ADDR_W-1:0] word_addr;
  logic              wb_req;
  logic              wb_any;
  logic              wb_dispatch;

  imem_wb_decode #(
    .BASE_ADDR   (BASE_ADDR),
    .CTRL_OFFSET (CTRL_OFFSET),
    .ADDR_W      (ADDR_W)
  ) u_decode (
    .wbs_adr_i (wbs_adr_i),
    .imem_hit  (imem_hit),
    .ctrl_hit  (ctrl_hit),
    .word_addr (word_addr)
  );

  assign wb_req = wbs_stb_i && wbs_cyc_i;
  assign wb_any = wb_req && (imem_hit || ctrl_hit);

`ifndef IMEM_READBACK_EN
  // Read data path is compiled out; keep the SRAM output visibly consumed.
  logic unused_dout0;
  assign unused_dout0 = ^dout0;
`endif

  // All outputs are registered; the *_next values describe the cycle that
  // follows, so SRAM controls are stable for the whole active-state cycle.
  always_comb begin
    state_next   = state_reg;
    csb0_next    = 1'b1;
    web0_next    = 1'b1;
    wmask0_next  = 4'h0;
    addr0_next   = addr0_reg;
    din0_next    = din0_reg;
    ack_next     = 1'b0;
    dat_next     = dat_reg;
    done_next    = 1'b0;
    hold_next    = hold_reg;
    la_last_next = la_last_reg;
    abort_next   = abort_reg;
    wb_dispatch  = 1'b0;

    case (state_reg)
      IDLE: begin
        // LA normally wins, except right after an LA service that left a
        // Wishbone request waiting.
        if (la_wr_req && !(la_last_reg && wb_any)) begin
          state_next   = LA_WR;
          csb0_next    = 1'b0;
          web0_next    = 1'b0;
          wmask0_next  = 4'hF;
          addr0_next   = la_addr;
          din0_next    = la_data;
          la_last_next = 1'b1;
        end else if (wb_any) begin
          wb_dispatch = 1'b1;
        end
      end
      LA_WR: begin
        state_next = DONE;
        done_next  = 1'b1;
      end
      DONE: begin
        // DONE is the Wishbone side's turn after an LA write. The LA side is
        // never re-served from here, giving the loader time to drop its level.
        if (wb_any) begin
          wb_dispatch = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      WB_WR: begin
        state_next = ACK;
        ack_next   = wbs_cyc_i && !abort_reg;
      end
      WB_RD: begin
        state_next = RD_WAIT;
        abort_next = abort_reg || !wbs_cyc_i;
      end
      RD_WAIT: begin
        state_next = ACK;
        ack_next   = wbs_cyc_i && !abort_reg;
`ifdef IMEM_READBACK_EN
        dat_next   = dout0;
`endif
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (wb_dispatch) begin
      la_last_next = 1'b0;
      abort_next   = 1'b0;
      if (ctrl_hit) begin
        state_next = ACK;
        ack_next   = 1'b1;
        if (wbs_we_i) begin
          if (wbs_sel_i[0]) begin
            hold_next = wbs_dat_i[0];
          end
        end else begin
          dat_next = ctrl_word(hold_reg);
        end
      end else if (wbs_we_i) begin
        state_next  = WB_WR;
        csb0_next   = 1'b0;
        web0_next   = 1'b0;
        wmask0_next = wbs_sel_i;
        addr0_next  = word_addr;
        din0_next   = wbs_dat_i;
      end else begin
`ifdef IMEM_READBACK_EN
        state_next = WB_RD;
        csb0_next  = 1'b0;
        addr0_next = word_addr;
`else
        state_next = ACK;
        ack_next   = 1'b1;
        dat_next   = '0;
`endif
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      csb0_reg       <= 1'b1;
      web0_reg       <= 1'b1;
      wmask0_reg     <= 4'h0;
      addr0_reg      <= '0;
      din0_reg       <= '0;
      ack_reg        <= 1'b0;
      dat_reg        <= '0;
      done_reg       <= 1'b0;
      hold_reg       <= 1'b1;
      core_reset_reg <= 1'b1;
      la_last_reg    <= 1'b0;
      abort_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      csb0_reg       <= csb0_next;
      web0_reg       <= web0_next;
      wmask0_reg     <= wmask0_next;
      addr0_reg      <= addr0_next;
      din0_reg       <= din0_next;
      ack_reg        <= ack_next;
      dat_reg        <= dat_next;
      done_reg       <= done_next;
      hold_reg       <= hold_next;
      core_reset_reg <= hold_reg;
      la_last_reg    <= la_last_next;
      abort_reg      <= abort_next;
    end
  end

  assign csb0       = csb0_reg;
  assign web0       = web0_reg;
  assign wmask0     = wmask0_reg;
  assign addr0      = addr0_reg;
  assign din0       = din0_reg;
  assign wbs_ack_o  = ack_reg;
  assign wbs_dat_o  = dat_reg;
  assign la_wr_done = done_reg;
  assign core_reset = core_reset_reg;

endmodule
